// File: rtl/ysyx_axi4_sram_responder.sv
// ysyx_axi4_sram_responder
//
// AXI4 responder modelling an on-chip SRAM of 2**DEPTH_LOG2 64-bit words
// mapped at BASE. Read and write channels are independent. Each channel
// handles one transaction at a time and has a programmable response latency.
// FIXED and INCR bursts are supported. WRAP bursts return SLVERR and write
// nothing. Memory contents are not reset.
//
// Handshake rule, on every channel: a transfer happens on the rising clk edge
// where valid and ready are both 1. Once this block raises a valid, it holds
// that valid and its payload stable until the matching ready is seen.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ar*                 read address channel (arsize is accepted, not checked)
//   r*                  read data channel
//   aw*                 write address channel (awsize is accepted, not checked)
//   w*                  write data channel, byte strobes in wstrb
//   b*                  write response channel
//   dbg_r_state         read FSM state  (0 idle, 1 wait, 2 data)
//   dbg_w_state         write FSM state (0 idle, 1 data, 2 latency, 3 resp)

module ysyx_axi4_sram_responder #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 64,
   parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
   parameter int                DEPTH_LOG2 = 12,
   parameter int                RD_LAT     = 2,
   parameter int                WR_LAT     = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [3:0]          arid,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic [3:0]          rid,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [3:0]          awid,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic [3:0]          bid,
   output logic                bvalid,
   input  logic                bready,
   output logic [1:0]          dbg_r_state,
   output logic [1:0]          dbg_w_state
);

   localparam int         WORDS      = 1 << DEPTH_LOG2;
   localparam int         STRB_W     = DATA_W / 8;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_SLV   = 2'b10;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_LAT = 2'd2, W_RESP = 2'd3} w_state_e;

   logic [DATA_W-1:0] mem [WORDS];

   r_state_e          r_state_q, r_state_d;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic [3:0]        r_id_q, r_id_d;
   logic [7:0]        r_len_q, r_len_d;
   logic [1:0]        r_burst_q, r_burst_d;
   logic [7:0]        r_beat_q, r_beat_d;
   logic [3:0]        r_cnt_q, r_cnt_d;

   w_state_e          w_state_q, w_state_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [3:0]        w_id_q, w_id_d;
   logic [7:0]        w_len_q, w_len_d;
   logic [1:0]        w_burst_q, w_burst_d;
   logic [7:0]        w_beat_q, w_beat_d;
   logic [3:0]        w_cnt_q, w_cnt_d;
   logic              w_err_q, w_err_d;

   // Decode of the current beat address. A beat is serviceable when it lies
   // inside the SRAM window and the burst is not WRAP (burst[1] set).
   logic [ADDR_W-1:0]     r_off, w_off;
   logic [DEPTH_LOG2-1:0] r_idx, w_idx;
   logic                  r_ok, w_ok, w_beat_last, mem_we;

   assign r_off = r_addr_q - BASE;
   assign w_off = w_addr_q - BASE;
   assign r_idx = r_off[DEPTH_LOG2+2:3];
   assign w_idx = w_off[DEPTH_LOG2+2:3];
   assign r_ok  = (r_addr_q >= BASE) && (r_off[ADDR_W-1:DEPTH_LOG2+3] == '0) && !r_burst_q[1];
   assign w_ok  = (w_addr_q >= BASE) && (w_off[ADDR_W-1:DEPTH_LOG2+3] == '0) && !w_burst_q[1];

   logic unused_bits;
   assign unused_bits = ^{arsize, awsize, r_off[2:0], w_off[2:0]};

   // ---------------- read channel ----------------
   always_comb begin
      r_state_d = r_state_q;
      r_addr_d  = r_addr_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_burst_d = r_burst_q;
      r_beat_d  = r_beat_q;
      r_cnt_d   = r_cnt_q;
      case (r_state_q)
         R_IDLE: begin
            if (arvalid) begin
               r_addr_d  = araddr;
               r_id_d    = arid;
               r_len_d   = arlen;
               r_burst_d = arburst;
               r_beat_d  = '0;
               if (RD_LAT == 0) begin
                  r_state_d = R_DATA;
               end else begin
                  r_cnt_d   = 4'(RD_LAT);
                  r_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            r_cnt_d = r_cnt_q - 4'd1;
            if (r_cnt_q <= 4'd1) r_state_d = R_DATA;
         end
         R_DATA: begin
            if (rready) begin
               if (r_beat_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_beat_d = r_beat_q + 8'd1;
                  if (r_burst_q == BURST_INCR) r_addr_d = r_addr_q + ADDR_W'(8);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Outputs are gated with rst so they read as zero for the whole reset
   // window, including the cycle before the first reset edge.
   assign arready = (r_state_q == R_IDLE) && !rst;
   assign rvalid  = (r_state_q == R_DATA) && !rst;
   assign rlast   = rvalid && (r_beat_q == r_len_q);
   assign rresp   = (rvalid && !r_ok) ? RESP_SLV : 2'b00;
   assign rid     = rvalid ? r_id_q : '0;
   // Asynchronous read so a write accepted at an edge is seen by the next beat.
   assign rdata   = (rvalid && r_ok) ? mem[r_idx] : '0;

   // ---------------- write channel ----------------
   assign w_beat_last = (w_beat_q == w_len_q);

   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_id_d    = w_id_q;
      w_len_d   = w_len_q;
      w_burst_d = w_burst_q;
      w_beat_d  = w_beat_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      case (w_state_q)
         W_IDLE: begin
            if (awvalid) begin
               w_addr_d  = awaddr;
               w_id_d    = awid;
               w_len_d   = awlen;
               w_burst_d = awburst;
               w_beat_d  = '0;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               // Error sticks for a dropped beat or a wlast that disagrees
               // with the beat count (early, or missing on the final beat).
               w_err_d  = w_err_q | !w_ok | (wlast ^ w_beat_last);
               w_beat_d = w_beat_q + 8'd1;
               if (w_burst_q == BURST_INCR) w_addr_d = w_addr_q + ADDR_W'(8);
               if (wlast || w_beat_last) begin
                  if (WR_LAT == 0) begin
                     w_state_d = W_RESP;
                  end else begin
                     w_cnt_d   = 4'(WR_LAT);
                     w_state_d = W_LAT;
                  end
               end
            end
         end
         W_LAT: begin
            w_cnt_d = w_cnt_q - 4'd1;
            if (w_cnt_q <= 4'd1) w_state_d = W_RESP;
         end
         W_RESP: begin
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign awready = (w_state_q == W_IDLE) && !rst;
   assign wready  = (w_state_q == W_DATA) && !rst;
   assign bvalid  = (w_state_q == W_RESP) && !rst;
   assign bresp   = (bvalid && w_err_q) ? RESP_SLV : 2'b00;
   assign bid     = bvalid ? w_id_q : '0;
   assign mem_we  = wvalid && wready && w_ok;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_burst_q <= '0;
         r_beat_q  <= '0;
         r_cnt_q   <= '0;
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_id_q    <= '0;
         w_len_q   <= '0;
         w_burst_q <= '0;
         w_beat_q  <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_burst_q <= r_burst_d;
         r_beat_q  <= r_beat_d;
         r_cnt_q   <= r_cnt_d;
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_id_q    <= w_id_d;
         w_len_q   <= w_len_d;
         w_burst_q <= w_burst_d;
         w_beat_q  <= w_beat_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
      end
   end

   assign dbg_r_state = r_state_q;
   assign dbg_w_state = w_state_q;

endmodule

// File: tb/tb_ysyx_axi4_sram_responder.sv
// Testbench for ysyx_axi4_sram_responder: directed AXI4 reads and writes.
// Strobed-write vectors come from a table. Burst, error, concurrency and
// reset-abort cases are hand-written sequences. Read data is checked against
// an expected queue.

module tb_ysyx_axi4_sram_responder;

   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic        clk, rst;
   logic [31:0] araddr, awaddr;
   logic [3:0]  arid, awid, rid, bid;
   logic [7:0]  arlen, awlen, wstrb;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [63:0] rdata, wdata;
   logic [1:0]  dbg_r_state, dbg_w_state;

   ysyx_axi4_sram_responder #(
      .ADDR_W(32), .DATA_W(64), .BASE(32'h8000_0000), .DEPTH_LOG2(12),
      .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
      .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
   );

   // ---------------- clock / reset ----------------
   int unsigned cyc = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];
   logic [1:0]  exp_resp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   logic [63:0] wb_data [16];
   logic [7:0]  wb_strb [16];
   logic        wb_last [16];

   // Issue one read; pat[k] is rready for the k-th cycle rvalid is high.
   task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [15:0] pat);
      int n = 0;
      int k = 0;
      int budget;
      int unsigned h;
      bit got_hs = 0;
      bit first = 1;
      bit stalled = 0;
      logic [63:0] held_data;
      logic        held_last;
      logic [1:0]  held_resp;
      @(posedge clk); #1;
      araddr = addr; arid = id; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
      for (budget = 0; budget < 50 && !got_hs; budget++) begin
         @(negedge clk);
         if (arready) got_hs = 1;
         @(posedge clk); #1;
      end
      h = cyc;
      arvalid = 1'b0;
      check("ar_handshake", 64'(got_hs), 64'd1);
      if (!got_hs) return;
      budget = 0;
      while (n <= int'(len) && budget < 200) begin
         rready = pat[k % 16];
         @(negedge clk);
         if (rvalid) begin
            if (first) begin
               check("rd_latency", 64'(cyc - h), 64'(RD_LAT));
               first = 0;
            end
            if (stalled) begin
               check("rd_stable", {rdata}, held_data);
               check("rd_stable_ctl", {rlast, rresp}, {held_last, held_resp});
               stalled = 0;
            end
            if (rready) begin
               check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  check("rd_data", rdata, exp_q.pop_front());
                  check("rd_resp", 64'(rresp), 64'(exp_resp_q.pop_front()));
               end
               check("rd_last", 64'(rlast), 64'(n == int'(len)));
               check("rd_id", 64'(rid), 64'(id));
               n++;
            end else begin
               held_data = rdata;
               held_last = rlast;
               held_resp = rresp;
               stalled = 1;
            end
            k++;
         end
         budget++;
         @(posedge clk); #1;
      end
      rready = 1'b0;
      check("rd_beat_count", 64'(n), 64'(int'(len) + 1));
   endtask

   // Issue one write of nb beats from wb_*; returns bresp/bid.
   task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input int nb,
                           output logic [1:0] resp, output logic [3:0] bid_o);
      int budget;
      int unsigned h;
      bit hs = 0;
      bit got = 0;
      resp = 2'b11;
      bid_o = '0;
      @(posedge clk); #1;
      awaddr = addr; awid = id; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
      for (budget = 0; budget < 50 && !hs; budget++) begin
         @(negedge clk);
         if (awready) hs = 1;
         @(posedge clk); #1;
      end
      awvalid = 1'b0;
      check("aw_handshake", 64'(hs), 64'd1);
      if (!hs) return;
      for (int i = 0; i < nb; i++) begin
         wdata = wb_data[i]; wstrb = wb_strb[i]; wlast = wb_last[i]; wvalid = 1'b1;
         hs = 0;
         for (budget = 0; budget < 50 && !hs; budget++) begin
            @(negedge clk);
            if (wready) hs = 1;
            @(posedge clk); #1;
         end
         check("w_handshake", 64'(hs), 64'd1);
         if (!hs) begin
            wvalid = 1'b0;
            return;
         end
      end
      h = cyc;
      wvalid = 1'b0; wlast = 1'b0;
      for (budget = 0; budget < 50 && !got; budget++) begin
         @(negedge clk);
         if (bvalid) got = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("b_arrive", 64'(got), 64'd1);
      if (!got) return;
      check("wr_latency", 64'(cyc - h), 64'(WR_LAT));
      resp = bresp;
      bid_o = bid;
      // Hold bready low one extra cycle: B must stay put.
      @(posedge clk); #1;
      @(negedge clk);
      check("b_hold", {bvalid, bresp, bid}, {1'b1, resp, bid_o});
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("b_done", 64'(bvalid), 64'd0);
   endtask

   // ---------------- strobed-write vector table ----------------
   typedef struct {
      logic [31:0] addr;
      logic [63:0] prior;
      logic [63:0] wdat;
      logic [7:0]  strb;
      logic [63:0] expw;
   } wvec_t;

   wvec_t tbl [6];

   // ---------------- main sequence ----------------
   logic [1:0] resp_v;
   logic [3:0] bid_v;
   bit         seen;

   initial begin
      rst = 1'b1;
      araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b1;
      awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b1;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;

      tbl[0] = '{32'h8000_0008, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0000_0000_FFFF_FFFF};
      tbl[1] = '{32'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 8'hF0,
                 64'hFEDC_BA98_89AB_CDEF};
      tbl[2] = '{32'h8000_0018, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 8'h81,
                 64'h55AA_AAAA_AAAA_AA55};
      tbl[3] = '{32'h8000_0020, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 8'h00,
                 64'h1111_1111_1111_1111};
      tbl[4] = '{32'h8000_0028, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D};
      tbl[5] = '{32'h8000_7FF8, 64'h0, 64'h0102_0304_0506_0708, 8'h3C, 64'h0000_0304_0506_0000};

      // Reset held 3 cycles with valids asserted: nothing may handshake.
      repeat (3) begin
         @(negedge clk);
         check("rst_ctl", {arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid}, 64'd0);
         check("rst_rdata", rdata, 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0; arvalid = 1'b0; awvalid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {arready, awready}, 64'b11);
      check("post_rst_other", {wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid}, 64'd0);
      check("post_rst_rdata", rdata, 64'd0);
      check("post_rst_state", {dbg_r_state, dbg_w_state}, 64'd0);

      // Strobed writes over a known prior value, then single-beat readback.
      for (int i = 0; i < 6; i++) begin
         wb_data[0] = tbl[i].prior; wb_strb[0] = 8'hFF; wb_last[0] = 1'b1;
         do_write(tbl[i].addr, 4'd1, 8'd0, 2'b01, 1, resp_v, bid_v);
         check("tbl_prior_bresp", 64'(resp_v), 64'd0);
         wb_data[0] = tbl[i].wdat; wb_strb[0] = tbl[i].strb; wb_last[0] = 1'b1;
         do_write(tbl[i].addr, 4'd2, 8'd0, 2'b01, 1, resp_v, bid_v);
         check("tbl_bresp", 64'(resp_v), 64'd0);
         check("tbl_bid", 64'(bid_v), 64'd2);
         exp_q.push_back(tbl[i].expw); exp_resp_q.push_back(2'b00);
         do_read(tbl[i].addr, 4'd4, 8'd0, 2'b01, 16'hFFFF);
      end

      // Preload words 0..3 with a 4-beat INCR write.
      wb_data[0] = 64'h1122_3344_5566_7788; wb_data[1] = 64'h0F0E_0D0C_0B0A_0908;
      wb_data[2] = 64'h1716_1514_1312_1110; wb_data[3] = 64'h1F1E_1D1C_1B1A_1918;
      for (int i = 0; i < 4; i++) begin
         wb_strb[i] = 8'hFF;
         wb_last[i] = (i == 3);
      end
      do_write(32'h8000_0000, 4'd1, 8'd3, 2'b01, 4, resp_v, bid_v);
      check("preload_bresp", 64'(resp_v), 64'd0);
      check("preload_bid", 64'(bid_v), 64'd1);

      // Single read of word 0.
      exp_q.push_back(64'h1122_3344_5566_7788); exp_resp_q.push_back(2'b00);
      do_read(32'h8000_0000, 4'd2, 8'd0, 2'b01, 16'hFFFF);

      // INCR burst with rready 1,0,1,1,0,1.
      exp_q.push_back(64'h1122_3344_5566_7788); exp_q.push_back(64'h0F0E_0D0C_0B0A_0908);
      exp_q.push_back(64'h1716_1514_1312_1110); exp_q.push_back(64'h1F1E_1D1C_1B1A_1918);
      repeat (4) exp_resp_q.push_back(2'b00);
      do_read(32'h8000_0000, 4'd9, 8'd3, 2'b01, 16'hFFED);

      // Below the window: SLVERR, zero data.
      exp_q.push_back(64'h0); exp_resp_q.push_back(2'b10);
      do_read(32'h7FFF_FFF8, 4'd6, 8'd0, 2'b01, 16'hFFFF);

      // Burst crossing the top of the window: only beat 1 errors.
      exp_q.push_back(64'h0000_0304_0506_0000); exp_resp_q.push_back(2'b00);
      exp_q.push_back(64'h0);                   exp_resp_q.push_back(2'b10);
      do_read(32'h8000_7FF8, 4'd7, 8'd1, 2'b01, 16'hFFFF);

      // WRAP write: SLVERR and word 5 unchanged.
      wb_data[0] = 64'h5555_5555_5555_5555; wb_strb[0] = 8'hFF; wb_last[0] = 1'b1;
      do_write(32'h8000_0028, 4'd8, 8'd0, 2'b10, 1, resp_v, bid_v);
      check("wrap_bresp", 64'(resp_v), 64'd2);
      exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D); exp_resp_q.push_back(2'b00);
      do_read(32'h8000_0028, 4'd8, 8'd0, 2'b01, 16'hFFFF);

      // awlen=1 with wlast on the first beat.
      wb_data[0] = 64'h0; wb_strb[0] = 8'hFF; wb_last[0] = 1'b1;
      do_write(32'h8000_0030, 4'd9, 8'd1, 2'b01, 1, resp_v, bid_v);
      check("early_wlast_bresp", 64'(resp_v), 64'd2);

      // awlen=0 with wlast missing.
      wb_last[0] = 1'b0;
      do_write(32'h8000_0038, 4'd10, 8'd0, 2'b01, 1, resp_v, bid_v);
      check("missing_wlast_bresp", 64'(resp_v), 64'd2);

      // FIXED burst: both beats hit word 10, the second one wins.
      wb_data[0] = 64'hAAAA_0000_AAAA_0000; wb_strb[0] = 8'hFF; wb_last[0] = 1'b0;
      wb_data[1] = 64'hBBBB_1111_BBBB_1111; wb_strb[1] = 8'hFF; wb_last[1] = 1'b1;
      do_write(32'h8000_0050, 4'd11, 8'd1, 2'b00, 2, resp_v, bid_v);
      check("fixed_bresp", 64'(resp_v), 64'd0);
      exp_q.push_back(64'hBBBB_1111_BBBB_1111); exp_resp_q.push_back(2'b00);
      do_read(32'h8000_0050, 4'd0, 8'd0, 2'b01, 16'hFFFF);

      // Concurrent read burst (id 3) and write burst (id 5) issued together.
      wb_data[0] = 64'hC0C0_C0C0_C0C0_C0C0; wb_strb[0] = 8'hFF; wb_last[0] = 1'b0;
      wb_data[1] = 64'hC1C1_C1C1_C1C1_C1C1; wb_strb[1] = 8'hFF; wb_last[1] = 1'b1;
      exp_q.push_back(64'h1122_3344_5566_7788); exp_q.push_back(64'h0F0E_0D0C_0B0A_0908);
      exp_q.push_back(64'h1716_1514_1312_1110); exp_q.push_back(64'h1F1E_1D1C_1B1A_1918);
      repeat (4) exp_resp_q.push_back(2'b00);
      fork
         do_read(32'h8000_0000, 4'd3, 8'd3, 2'b01, 16'hFFFF);
         do_write(32'h8000_0040, 4'd5, 8'd1, 2'b01, 2, resp_v, bid_v);
      join
      check("conc_bresp", 64'(resp_v), 64'd0);
      check("conc_bid", 64'(bid_v), 64'd5);
      exp_q.push_back(64'hC0C0_C0C0_C0C0_C0C0); exp_q.push_back(64'hC1C1_C1C1_C1C1_C1C1);
      repeat (2) exp_resp_q.push_back(2'b00);
      do_read(32'h8000_0040, 4'd3, 8'd1, 2'b01, 16'hFFFF);

      // Reset in the middle of a read and a write: no R or B afterwards.
      @(posedge clk); #1;
      araddr = 32'h8000_0000; arid = 4'd1; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
      awaddr = 32'h8000_0060; awid = 4'd2; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0;
      wdata = 64'h1234; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0; rst = 1'b1; rready = 1'b1; bready = 1'b1;
      @(negedge clk);
      check("abort_setup", {dbg_r_state, dbg_w_state}, {2'd1, 2'd2});
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (rvalid || bvalid) seen = 1;
         @(posedge clk); #1;
      end
      check("abort_no_beats", 64'(seen), 64'd0);
      @(negedge clk);
      check("abort_ready", {arready, awready}, 64'b11);
      rready = 1'b0; bready = 1'b0;
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_axi4_sram_responder.md
# ysyx_axi4_sram_responder

AXI4 slave (responder) modelling an on-chip SRAM behind the bus arbiter's master port. Accepts one read and one write transaction at a time, on independent channels, with programmable response latency. Supports single-beat and burst transfers with byte-strobed writes. Serves as the memory endpoint for standalone NPC simulation and as the reference responder for arbiter verification.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data bus width; fixed at 64 (8-byte beats)
- BASE, 32'h8000_0000, first byte address mapped to the SRAM
- DEPTH_LOG2, 12, log2 of SRAM depth in 64-bit words
- RD_LAT, 2, extra cycles between AR handshake and first R beat (0..15)
- WR_LAT, 1, extra cycles between last W handshake and B (0..15)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- araddr/arid/arlen/arsize/arburst  in  ADDR_W/4/8/3/2  read address channel
- arvalid  in  1;  arready  out  1
- rdata  out  64;  rresp  out  2;  rid  out  4;  rlast  out  1
- rvalid  out  1;  rready  in  1
- awaddr/awid/awlen/awsize/awburst  in  ADDR_W/4/8/3/2  write address channel
- awvalid  in  1;  awready  out  1
- wdata  in  64;  wstrb  in  8;  wlast  in  1;  wvalid  in  1;  wready  out  1
- bresp  out  2;  bid  out  4;  bvalid  out  1;  bready  in  1

## Operation
- Word index = (addr - BASE) >> 3; in range iff BASE <= addr < BASE + 8·2^DEPTH_LOG2. arsize/awsize accepted but not checked; beat addressing is always 8-byte.
- Burst: FIXED (00) keeps the address; INCR (01) adds 8 per beat; WRAP (10/11) unsupported → every beat SLVERR.
- Read FSM: R_IDLE (arready=1) → on AR handshake latch addr/id/len/burst and load latency counter → R_WAIT (count down RD_LAT) → R_DATA (rvalid=1; rdata from memory at the current word) → on R handshake: rlast beat → R_IDLE, otherwise advance address and stay.
- rlast=1 only on beat arlen. rid = latched arid.
- Read of an out-of-range word: rdata=0, rresp=2'b10 for that beat; other beats are unaffected.
- Write FSM: W_IDLE (awready=1, wready=0) → on AW handshake → W_DATA (wready=1); each W handshake writes the bytes with wstrb[i]=1 to the current word, then advances.
- Leave W_DATA on wlast or after beat awlen → W_LAT (count WR_LAT) → W_RESP (bvalid=1) → on bready → W_IDLE.
- bresp=SLVERR if any beat was out of range, the burst type was WRAP, or wlast mismatched the beat count (early, or missing on beat awlen). Otherwise OKAY. bid = latched awid.
- Out-of-range and WRAP beats are dropped: they are handshaken but not written.
- Read and write channels run concurrently. A write beat accepted at edge N is visible to any read beat whose rdata is sampled after edge N.
- Memory contents are not reset.

## Timing
- While rst=1: arready=awready=wready=rvalid=bvalid=rlast=0, rdata=0, rresp=bresp=0, rid=bid=0, both FSMs in IDLE, counters cleared.
- First cycle after rst deasserts: arready=1, awready=1.
- Reset mid-transaction aborts it: there is no B or remaining R beat afterwards.
- AR handshake at cycle T → first rvalid at T+1+RD_LAT. Subsequent beats: 1 per cycle while rready=1.
- rvalid/rdata/rlast/rresp are held stable while rvalid=1 and rready=0.
- Last W handshake at T → bvalid at T+1+WR_LAT. bvalid and bresp are held until bready.
- arready is low from the AR handshake until the cycle after the final R handshake. awready follows the same rule with respect to B.
- wready is never high in W_IDLE. W beats presented before the AW handshake wait.

## Test plan
- Reset: hold rst for 3 cycles with arvalid=1 → no handshake; arready=awready=1 in the first cycle after release; all other outputs 0.
- Single read, RD_LAT=2: preload word 0 = 64'h1122334455667788; AR araddr=0x80000000, arlen=0 at T → rvalid, rlast=1, rresp=0 at T+3 with that data.
- INCR burst, arlen=3, with rready toggling 1,0,1,1,0,1 → words 0..3 returned in order; data is stable while stalled; rlast on the 4th beat only.
- Strobed write: awaddr=0x80000008, wdata=64'hFFFF_FFFF_FFFF_FFFF, wstrb=8'h0F, wlast=1 over a prior 0 → bresp=0 at last-W+2; readback gives 64'h0000_0000_FFFF_FFFF.
- Error cases:
  - araddr=0x7FFFFFF8 → rresp=2'b10, rdata=0.
  - awburst=WRAP → bresp=2'b10, memory unchanged.
  - awlen=1 with wlast on the first beat → bresp=2'b10.
- Concurrent traffic: a read burst and a write burst issued in the same cycle → both complete. A later read of the written words returns the new data; rid and bid match arid=3 and awid=5.
